// File: rtl/sha3_squeeze_ctrl_if.sv
// Output-side handshake bundle between the SHA3 core, the squeeze controller
// and the destination port.
//   master : core/destination side (drives start, size, backpressure, done)
//   slave  : squeeze controller (drives writes, clears, squeeze request, mask)
interface sha3_squeeze_ctrl_if #(
  parameter int unsigned W       = 64,
  parameter int unsigned OSIZE_W = 16
) ();
  logic               output_write;
  logic [OSIZE_W-1:0] output_size;
  logic               dst_full;
  logic               squeeze_done;
  logic               dst_write;
  logic               eo;
  logic               output_write_clr;
  logic               output_busy_clr;
  logic               squeeze_req;
  logic               last_out_word;
  logic [W/8-1:0]     last_bytes;

  modport master (
    output output_write, output_size, dst_full, squeeze_done,
    input  dst_write, eo, output_write_clr, output_busy_clr,
           squeeze_req, last_out_word, last_bytes
  );

  modport slave (
    input  output_write, output_size, dst_full, squeeze_done,
    output dst_write, eo, output_write_clr, output_busy_clr,
           squeeze_req, last_out_word, last_bytes
  );
endinterface

// File: rtl/sha3_squeeze_ctrl.sv
// Output-side controller for the SHA3/SHAKE core. Streams ceil(output_size/W)
// words to the destination with backpressure, requesting extra permutations
// at rate-block boundaries, and flags the final word with its byte mask.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : sha3_squeeze_ctrl_if.slave (start/size/backpressure/squeeze
//              inputs; write/clear/squeeze-request/last-word/mask outputs)
// Outputs are combinational from state, counters and inputs, held 0 in reset.
module sha3_squeeze_ctrl #(
  parameter int unsigned W          = 64,
  parameter int unsigned RATE_WORDS = 21,
  parameter int unsigned OSIZE_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  sha3_squeeze_ctrl_if.slave     bus
);

  localparam int unsigned LW    = $clog2(W);
  localparam int unsigned REM_W = OSIZE_W - LW + 1;
  localparam int unsigned BLK_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam int unsigned WB    = W / 8;
  localparam int unsigned NB_W  = $clog2(WB) + 1;

  typedef enum logic [1:0] {IDLE, XFER, SQZ} state_t;

  state_t            state_q, state_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [LW-1:0]     rbits_q, rbits_d;
  logic              sqz_first_q, sqz_first_d;

  logic              wr, wclr, bclr, sqreq, last;
  logic [WB-1:0]     lbytes;

  logic [OSIZE_W:0]  size_sum;
  logic [REM_W-1:0]  total;
  logic [LW:0]       rsum;
  logic [NB_W-1:0]   nbytes;
  logic [WB-1:0]     ones;
  logic [WB-1:0]     tail_mask;

  // Word count rounded up, and MSB-aligned valid-byte mask for the last word
  always_comb begin
    size_sum  = (OSIZE_W+1)'(bus.output_size) + (OSIZE_W+1)'(W - 1);
    total     = REM_W'(size_sum >> LW);
    rsum      = {1'b0, rbits_q} + (LW+1)'(7);
    nbytes    = NB_W'(rsum >> 3);
    ones      = '1;
    tail_mask = (nbytes == '0) ? ones : ~(ones >> nbytes);
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      blk_q       <= '0;
      rbits_q     <= '0;
      sqz_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      blk_q       <= blk_d;
      rbits_q     <= rbits_d;
      sqz_first_q <= sqz_first_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    blk_d       = blk_q;
    rbits_d     = rbits_q;
    sqz_first_d = 1'b0;
    wr          = 1'b0;
    wclr        = 1'b0;
    bclr        = 1'b0;
    sqreq       = 1'b0;
    last        = 1'b0;
    lbytes      = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.output_write) begin
          wclr    = 1'b1;
          rem_d   = total;
          blk_d   = '0;
          rbits_d = bus.output_size[LW-1:0];
          if (total == '0) bclr    = 1'b1;
          else             state_d = XFER;
        end
      end
      XFER: begin
        last   = (rem_q == REM_W'(1));
        lbytes = last ? tail_mask : ones;
        if (!bus.dst_full) begin
          wr    = 1'b1;
          rem_d = rem_q - REM_W'(1);
          if (last) begin
            bclr    = 1'b1;
            state_d = IDLE;
          end else if (blk_q == BLK_W'(RATE_WORDS - 1)) begin
            // Rate block exhausted with words still owed: squeeze again
            blk_d       = '0;
            state_d     = SQZ;
            sqz_first_d = 1'b1;
          end else begin
            blk_d = blk_q + BLK_W'(1);
          end
        end
      end
      SQZ: begin
        lbytes = ones;
        sqreq  = sqz_first_q;
        if (bus.squeeze_done) state_d = XFER;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      wr     = 1'b0;
      wclr   = 1'b0;
      bclr   = 1'b0;
      sqreq  = 1'b0;
      last   = 1'b0;
      lbytes = '0;
    end
  end

  assign bus.dst_write        = wr;
  assign bus.eo               = wr;
  assign bus.output_write_clr = wclr;
  assign bus.output_busy_clr  = bclr;
  assign bus.squeeze_req      = sqreq;
  assign bus.last_out_word    = last;
  assign bus.last_bytes       = lbytes;

endmodule

// File: tb/tb_sha3_squeeze_ctrl.sv
// Directed bench for sha3_squeeze_ctrl: per-cycle vector table for single
// block transfers, then hand sequences for stalls, squeezes and reset.
module tb_sha3_squeeze_ctrl;
  localparam int unsigned W          = 64;
  localparam int unsigned RATE_WORDS = 21;
  localparam int unsigned OSIZE_W    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha3_squeeze_ctrl_if #(.W(W), .OSIZE_W(OSIZE_W)) bus ();

  sha3_squeeze_ctrl #(.W(W), .RATE_WORDS(RATE_WORDS), .OSIZE_W(OSIZE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        r, ow;
    logic [15:0] sz;
    logic        full, sd;
    logic        e_wr, e_wclr, e_bclr, e_sq, e_last;
    logic [7:0]  e_lb;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int writes;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Apply inputs away from the rising edge, then sample combinational outputs
  task automatic drive(input logic r, input logic ow, input logic [15:0] sz, input logic full, input logic sd);
    @(negedge clk);
    rst              = r;
    bus.output_write = ow;
    bus.output_size  = sz;
    bus.dst_full     = full;
    bus.squeeze_done = sd;
    #1;
  endtask

  task automatic check_all(input string name, input int idx, input logic wr, input logic wclr,
                           input logic bclr, input logic sq, input logic last, input logic [7:0] lb);
    chk({name, ".dst_write"}, idx, 8'(bus.dst_write), 8'(wr));
    chk({name, ".eo"},        idx, 8'(bus.eo), 8'(wr));
    chk({name, ".wclr"},      idx, 8'(bus.output_write_clr), 8'(wclr));
    chk({name, ".bclr"},      idx, 8'(bus.output_busy_clr), 8'(bclr));
    chk({name, ".sqreq"},     idx, 8'(bus.squeeze_req), 8'(sq));
    chk({name, ".last"},      idx, 8'(bus.last_out_word), 8'(last));
    chk({name, ".lbytes"},    idx, bus.last_bytes, lb);
  endtask

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic ow, input logic [15:0] sz, input logic full,
                              input logic sd, input logic wr, input logic wclr, input logic bclr,
                              input logic sq, input logic last, input logic [7:0] lb);
    vec_t v;
    v.r = r; v.ow = ow; v.sz = sz; v.full = full; v.sd = sd;
    v.e_wr = wr; v.e_wclr = wclr; v.e_bclr = bclr; v.e_sq = sq; v.e_last = last; v.e_lb = lb;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    bus.output_write = 1'b0;
    bus.output_size  = '0;
    bus.dst_full     = 1'b0;
    bus.squeeze_done = 1'b0;

    //          r  ow  size  full sd  wr wclr bclr sq last lb
    vt.push_back(mk(1, 1,   256, 0, 0,  0, 0, 0, 0, 0, 8'h00)); // reset forces 0
    vt.push_back(mk(1, 0,     0, 0, 0,  0, 0, 0, 0, 0, 8'h00));
    vt.push_back(mk(0, 0,     0, 0, 0,  0, 0, 0, 0, 0, 8'h00)); // idle after reset
    vt.push_back(mk(0, 1,   256, 0, 0,  0, 1, 0, 0, 0, 8'h00)); // 256b start
    vt.push_back(mk(0, 0,     0, 0, 0,  1, 0, 0, 0, 0, 8'hFF));
    vt.push_back(mk(0, 0,     0, 0, 0,  1, 0, 0, 0, 0, 8'hFF));
    vt.push_back(mk(0, 0,     0, 0, 0,  1, 0, 0, 0, 0, 8'hFF));
    vt.push_back(mk(0, 0,     0, 0, 0,  1, 0, 1, 0, 1, 8'hFF));
    vt.push_back(mk(0, 1,    20, 0, 0,  0, 1, 0, 0, 0, 8'h00)); // 20b: back-to-back start
    vt.push_back(mk(0, 0,     0, 0, 0,  1, 0, 1, 0, 1, 8'hE0));
    vt.push_back(mk(0, 1,    72, 0, 0,  0, 1, 0, 0, 0, 8'h00)); // 72b
    vt.push_back(mk(0, 0,     0, 0, 0,  1, 0, 0, 0, 0, 8'hFF));
    vt.push_back(mk(0, 0,     0, 0, 0,  1, 0, 1, 0, 1, 8'h80));
    vt.push_back(mk(0, 1,     0, 0, 0,  0, 1, 1, 0, 0, 8'h00)); // zero-length request
    vt.push_back(mk(0, 0,     0, 0, 0,  0, 0, 0, 0, 0, 8'h00));
    vt.push_back(mk(0, 1,    65, 0, 0,  0, 1, 0, 0, 0, 8'h00)); // 65b -> 2 words, 1 byte tail
    vt.push_back(mk(0, 0,     0, 0, 0,  1, 0, 0, 0, 0, 8'hFF));
    vt.push_back(mk(0, 0,     0, 0, 0,  1, 0, 1, 0, 1, 8'h80));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].r, vt[i].ow, vt[i].sz, vt[i].full, vt[i].sd);
      check_all("vec", i, vt[i].e_wr, vt[i].e_wclr, vt[i].e_bclr, vt[i].e_sq, vt[i].e_last, vt[i].e_lb);
    end

    // 256b with dst_full high on alternate cycles: 4 writes over 8 cycles
    drive(0, 1, 256, 0, 0);
    check_all("stall_start", 0, 0, 1, 0, 0, 0, 8'h00);
    writes = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, (i % 2 == 0), 0);
      check_all("stall", i, (i % 2 == 1), 0, (i == 7), 0, (i >= 6), 8'hFF);
      if (bus.dst_write) writes++;
    end
    chk("stall_writes", 0, 8'(writes), 8'd4);
    // dst_full held: stays in XFER, no writes (one word requested)
    drive(0, 1, 64, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1, 0);
      check_all("hold", i, 0, 0, 0, 0, 1, 8'hFF);
    end
    drive(0, 0, 0, 0, 0);
    check_all("hold_release", 0, 1, 0, 1, 0, 1, 8'hFF);

    // 42 words: two full rate blocks with one squeeze, done held off 5 cycles
    drive(0, 1, 2688, 0, 0);
    check_all("sq42_start", 0, 0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 21; i++) begin
      drive(0, 0, 0, 0, 0);
      check_all("sq42_blk1", i, 1, 0, 0, 0, 0, 8'hFF);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0);
      check_all("sq42_wait", i, 0, 0, 0, (i == 0), 0, 8'hFF);
    end
    drive(0, 0, 0, 0, 1);
    check_all("sq42_done", 0, 0, 0, 0, 0, 0, 8'hFF);
    for (int i = 0; i < 21; i++) begin
      drive(0, 0, 0, 0, 0);
      check_all("sq42_blk2", i, 1, 0, (i == 20), 0, (i == 20), 8'hFF);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      check_all("sq42_after", i, 0, 0, 0, 0, 0, 8'h00);
    end

    // 22 words: squeeze_done accepted in the first SQZ cycle
    drive(0, 1, 1408, 0, 0);
    for (int i = 0; i < 21; i++) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    check_all("sq22_first", 0, 0, 0, 0, 1, 0, 8'hFF);
    drive(0, 0, 0, 0, 0);
    check_all("sq22_last", 0, 1, 0, 1, 0, 1, 8'hFF);

    // Reset after 3 of 10 words, then a fresh 128b request
    drive(0, 1, 640, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check_all("rst_mid", 0, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 0);
    check_all("rst_after", 0, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 1, 128, 0, 0);
    check_all("fresh_start", 0, 0, 1, 0, 0, 0, 8'h00);
    drive(0, 1, 640, 0, 0); // start pulsed during XFER is ignored
    check_all("fresh_w1", 0, 1, 0, 0, 0, 0, 8'hFF);
    drive(0, 0, 0, 0, 0);
    check_all("fresh_w2", 0, 1, 0, 1, 0, 1, 8'hFF);
    drive(0, 0, 0, 0, 0);
    check_all("fresh_idle", 0, 0, 0, 0, 0, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
